// File: rtl/word_gather.sv
// word_gather
//   Packs a stream of N-bit words into frames of up to M words for the
//   per-lane register stage. A frame completes after M words or on an early
//   in_last. A single frame of skid storage lets collection finish while the
//   previously completed frame still waits downstream.
//
// Ports
//   clock      posedge clock for all state
//   rstn       asynchronous active-low reset
//   in_valid   in_data holds a word
//   in_ready   a word can be accepted this cycle (low while a frame is pending)
//   in_data    input word
//   in_last    the current word ends the frame (only when in_valid=1)
//   out_valid  out_data/out_count hold a complete frame
//   out_ready  downstream takes the frame this cycle
//   out_data   frame, slot 0 = first word, unwritten slots read 0
//   out_count  number of valid slots, 1..M
module word_gather #(
   parameter int N = 2,
   parameter int M = 2,
   localparam int CW = $clog2(M + 1)
) (
   input  logic          clock,
   input  logic          rstn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data [M],
   output logic [CW-1:0] out_count
);

   localparam int IW = (M > 1) ? $clog2(M) : 1;

   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [N-1:0]  cbuf_q [M];
   logic [N-1:0]  cbuf_d [M];
   logic          pend_q, pend_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  out_data_q [M];
   logic [N-1:0]  out_data_d [M];
   logic [CW-1:0] out_count_q, out_count_d;

   logic          acc;
   logic          done;
   logic          out_free;
   logic [N-1:0]  merged [M];

   assign in_ready = !pend_q;
   assign acc      = in_valid & in_ready;
   assign done     = acc & ((wr_idx_q == IW'(M - 1)) | in_last);
   assign out_free = !out_valid_q | out_ready;

   // Collect buffer with the word accepted this cycle dropped into its slot.
   for (genvar i = 0; i < M; i++) begin : g_slot
      assign merged[i] = (acc && (wr_idx_q == IW'(i))) ? in_data : cbuf_q[i];
   end

   always_comb begin
      wr_idx_d    = wr_idx_q;
      cbuf_d      = cbuf_q;
      pend_d      = pend_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;

      if (pend_q) begin
         // A finished frame waits in cbuf; nothing is accepted meanwhile.
         // wr_idx still points at its last slot, so count is wr_idx+1.
         if (out_ready) begin
            out_data_d  = cbuf_q;
            out_count_d = CW'(wr_idx_q) + CW'(1);
            out_valid_d = 1'b1;
            pend_d      = 1'b0;
            wr_idx_d    = '0;
            cbuf_d      = '{default: '0};
         end
      end else if (done) begin
         if (out_free) begin
            out_data_d  = merged;
            out_count_d = CW'(wr_idx_q) + CW'(1);
            out_valid_d = 1'b1;
            wr_idx_d    = '0;
            cbuf_d      = '{default: '0};
         end else begin
            cbuf_d = merged;
            pend_d = 1'b1;
         end
      end else begin
         if (acc) begin
            cbuf_d   = merged;
            wr_idx_d = wr_idx_q + IW'(1);
         end
         // Data and count are left holding their last values.
         if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         wr_idx_q    <= '0;
         cbuf_q      <= '{default: '0};
         pend_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '{default: '0};
         out_count_q <= '0;
      end else begin
         wr_idx_q    <= wr_idx_d;
         cbuf_q      <= cbuf_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_word_gather.sv
// tb_word_gather
//   Directed-vector bench for word_gather with N=2, M=2. Frames are shown as
//   {slot0, slot1}.
module tb_word_gather;

   logic       clock;
   logic       rstn;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_data [2];
   logic [1:0] out_count;

   int vectors;
   int miscompares;

   word_gather #(.N(2), .M(2)) dut (
      .clock     (clock),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [3:0] frame();
      return {out_data[0], out_data[1]};
   endfunction

   // Advance past the next rising edge and settle before sampling.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] d, input logic l);
      in_valid = v;
      in_data  = d;
      in_last  = l;
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if (out_valid !== 1'b0 || frame() !== 4'h0 || out_count !== 2'd0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset: valid=%b frame=%h count=%0d in_ready=%b, need 0/0/0/1",
                  out_valid, frame(), out_count, in_ready);
      end
      step();
      rstn = 1'b1;
      step();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_after_reset: valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_full_frame();
      out_ready = 1'b1;
      drive(1'b1, 2'h1, 1'b0);
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL full_mid: valid=%b, need 0", out_valid);
      end
      drive(1'b1, 2'h2, 1'b0);
      step();
      vectors++;
      if (out_valid !== 1'b1 || frame() !== 4'b0110 || out_count !== 2'd2) begin
         miscompares++;
         $display("FAIL full_frame: valid=%b frame=%h count=%0d, need 1/6/2",
                  out_valid, frame(), out_count);
      end
      drive(1'b0, 2'h0, 1'b0);
      step();
      vectors++;
      if (out_valid !== 1'b0 || frame() !== 4'b0110 || out_count !== 2'd2) begin
         miscompares++;
         $display("FAIL full_drain_hold: valid=%b frame=%h count=%0d, need 0/6/2",
                  out_valid, frame(), out_count);
      end
   endtask

   task automatic test_short_frame();
      out_ready = 1'b1;
      // in_last without in_valid must not end anything.
      drive(1'b0, 2'h2, 1'b1);
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL last_no_valid: valid=%b, need 0", out_valid);
      end
      drive(1'b1, 2'h3, 1'b1);
      step();
      vectors++;
      if (out_valid !== 1'b1 || frame() !== 4'b1100 || out_count !== 2'd1) begin
         miscompares++;
         $display("FAIL short_frame: valid=%b frame=%h count=%0d, need 1/c/1",
                  out_valid, frame(), out_count);
      end
      drive(1'b1, 2'h1, 1'b0);
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL short_next_mid: valid=%b, need 0", out_valid);
      end
      drive(1'b1, 2'h2, 1'b1);
      step();
      vectors++;
      if (out_valid !== 1'b1 || frame() !== 4'b0110 || out_count !== 2'd2) begin
         miscompares++;
         $display("FAIL short_next_frame: valid=%b frame=%h count=%0d, need 1/6/2",
                  out_valid, frame(), out_count);
      end
      drive(1'b0, 2'h0, 1'b0);
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 2'h1, 1'b0);
      step();
      drive(1'b1, 2'h2, 1'b0);
      step();
      vectors++;
      if (out_valid !== 1'b1 || frame() !== 4'b0110) begin
         miscompares++;
         $display("FAIL bp_first: valid=%b frame=%h, need 1/6", out_valid, frame());
      end
      drive(1'b1, 2'h3, 1'b0);
      step();
      drive(1'b1, 2'h1, 1'b0);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_ready_before_4th: in_ready=%b, need 1", in_ready);
      end
      step();
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || frame() !== 4'b0110 || out_count !== 2'd2) begin
         miscompares++;
         $display("FAIL bp_pending: in_ready=%b valid=%b frame=%h count=%0d, need 0/1/6/2",
                  in_ready, out_valid, frame(), out_count);
      end
      drive(1'b0, 2'h0, 1'b0);
      step();
      vectors++;
      if (in_ready !== 1'b0 || frame() !== 4'b0110) begin
         miscompares++;
         $display("FAIL bp_stable: in_ready=%b frame=%h, need 0/6", in_ready, frame());
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || frame() !== 4'b1101 || out_count !== 2'd2 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release: valid=%b frame=%h count=%0d in_ready=%b, need 1/d/2/1",
                  out_valid, frame(), out_count, in_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || frame() !== 4'b1101) begin
         miscompares++;
         $display("FAIL bp_hold2: valid=%b frame=%h, need 1/d", out_valid, frame());
      end
      out_ready = 1'b1;
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_drain: valid=%b, need 0", out_valid);
      end
   endtask

   task automatic test_streaming();
      logic [1:0] words [8];
      logic [3:0] exp_frame;
      int         frames;
      words  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
      frames = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, words[i], 1'b0);
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_ready[%0d]: in_ready=%b, need 1", i, in_ready);
         end
         step();
         if (i % 2 == 1) begin
            exp_frame = {words[i-1], words[i]};
            if (out_valid === 1'b1) frames++;
            vectors++;
            if (out_valid !== 1'b1 || frame() !== exp_frame || out_count !== 2'd2) begin
               miscompares++;
               $display("FAIL stream_frame[%0d]: valid=%b frame=%h count=%0d, need 1/%h/2",
                        i, out_valid, frame(), out_count, exp_frame);
            end
         end
      end
      drive(1'b0, 2'h0, 1'b0);
      step();
      vectors++;
      if (frames != 4 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stream_total: frames=%0d valid=%b, need 4/0", frames, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] words [4];
      words = '{2'd2, 2'd1, 2'd3, 2'd1};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, words[i], 1'b1);
         step();
         vectors++;
         if (out_valid !== 1'b1 || frame() !== {words[i], 2'b00} || out_count !== 2'd1) begin
            miscompares++;
            $display("FAIL b2b[%0d]: valid=%b frame=%h count=%0d, need 1/%h/1",
                     i, out_valid, frame(), out_count, {words[i], 2'b00});
         end
      end
      drive(1'b0, 2'h0, 1'b0);
      step();
   endtask

   task automatic test_reset_mid_frame();
      // Leave a blocked frame plus a partial word, then reset mid-cycle.
      out_ready = 1'b0;
      drive(1'b1, 2'h1, 1'b0);
      step();
      drive(1'b1, 2'h2, 1'b0);
      step();
      drive(1'b1, 2'h2, 1'b0);
      step();
      drive(1'b0, 2'h0, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || frame() !== 4'h0 || out_count !== 2'd0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid: valid=%b frame=%h count=%0d in_ready=%b, need 0/0/0/1",
                  out_valid, frame(), out_count, in_ready);
      end
      step();
      rstn = 1'b1;
      out_ready = 1'b1;
      step();
      drive(1'b1, 2'h1, 1'b0);
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_fresh_mid: valid=%b, need 0", out_valid);
      end
      drive(1'b1, 2'h3, 1'b0);
      step();
      vectors++;
      if (out_valid !== 1'b1 || frame() !== 4'b0111 || out_count !== 2'd2) begin
         miscompares++;
         $display("FAIL reset_fresh_frame: valid=%b frame=%h count=%0d, need 1/7/2",
                  out_valid, frame(), out_count);
      end
      drive(1'b0, 2'h0, 1'b0);
      step();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstn        = 1'b0;
      in_valid    = 1'b0;
      in_data     = 2'h0;
      in_last     = 1'b0;
      out_ready   = 1'b0;
      test_reset();
      test_full_frame();
      test_short_frame();
      test_backpressure();
      test_streaming();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
